memory_stage: RTL
=================

Name: memory_stage

Overview:
- MEM stage of the 5-stage 64-bit pipeline, between execute and writeback; produces the `memory_data_t` record that writeback consumes unchanged.
- Non-memory ops pass through a pipeline register.
- Loads/stores run a request/response handshake on the data bus, stall upstream while it is outstanding, and format store data/strobes and load results.

Parameters:
- ADDR_W, 64, width of the effective address and of `dbus_addr`.
- DATA_W, 64, data bus width; byte lanes = DATA_W/8 = 8.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-high reset.
- dataE  in  execute_data_t  execute record:
  - pc, result (ALU value or effective address), ctl, dst, store_data (rs2), is_bubble.
  - ctl carries op, mem_read, mem_write, msize[1:0], mem_unsigned.
- flush  in  1  kill the instruction currently in MEM (branch/exception redirect).
- stallM  out  1  hold execute and earlier stages this cycle.
- dataM  out  memory_data_t  registered record to writeback: pc, result, ctl, dst, memory_address, is_bubble.
- misalign  out  1  registered; dataM instruction was a misaligned access, suppressed.
- dbus_valid  out  1  request valid.
- dbus_addr  out  ADDR_W  byte address, low 3 bits preserved.
- dbus_size  out  2  0=1B, 1=2B, 2=4B, 3=8B.
- dbus_strobe  out  8  byte write enables; all zero for loads.
- dbus_wdata  out  DATA_W  lane-aligned store data.
- dbus_addr_ok  in  1  request accepted.
- dbus_data_ok  in  1  response complete; dbus_rdata valid this cycle.
- dbus_rdata  in  DATA_W  8-byte-aligned read word.

Behaviour:
- Reset (async, immediate):
  - dataM = all zero with is_bubble=1.
  - misalign=0, FSM=IDLE.
  - dbus_valid=0, dbus_strobe=0, stallM=0.
- mem op = !is_bubble && (mem_read || mem_write).
- aligned = addr[msize-1:0]==0 (msize=0 is always aligned).
- FSM states: IDLE, WAIT, DRAIN.
- IDLE:
  - Non-mem op, or bubble: dataM <= dataE on the next edge (latency 1), stallM=0.
  - Aligned mem op with no flush: dbus_valid=1 combinationally, stallM=1, go to WAIT.
  - If dbus_data_ok is already high in this cycle, complete immediately: no WAIT, stallM=0.
  - Misaligned mem op: no bus request, stallM=0; register dataM with is_bubble=1, misalign=1, memory_address=addr.
- WAIT:
  - dbus_valid and all request fields held stable until dbus_data_ok.
  - dbus_addr_ok is informational; completion is data_ok.
  - stallM=1 every cycle in WAIT except the data_ok cycle.
  - On data_ok: stallM=0; dataM <= formatted result; go to IDLE.
- While stalled, dataM <= bubble (is_bubble=1) each edge, so writeback sees no duplicate.
- flush:
  - In IDLE: dataE is treated as bubble, no request issued.
  - In WAIT without data_ok: go to DRAIN. The bus cannot abort, so the request is held until data_ok, and the response is discarded.
  - flush coinciding with data_ok: result discarded, go to IDLE.
- DRAIN: stallM=0, dbus_valid held until data_ok, then IDLE. Any new mem op waits in execute; stallM=1 only if a new mem op is present.
- Store formatting:
  - off = addr[2:0].
  - strobe = ((1<<(1<<msize))-1) << off, truncated to 8 bits.
  - wdata = store_data << (8*off).
- Load formatting:
  - raw = dbus_rdata >> (8*off), truncated to 8<<msize bits.
  - Sign-extend unless mem_unsigned, then zero-extend to 64.
  - dataM.result = formatted value.
- Stores: dataM.result = dataE.result.
- memory_address = addr for every mem op.
- All other dataM fields are copied from dataE.

Decomposition:
- Shared pipes package: execute_data_t, memory_data_t, and an msize_t enum MSIZE1/2/4/8.
- Shared common package: dbus request/response field widths.
- FSM state enum stays local.
- One natural sub-module, `mem_align`, purely combinational: addr/msize/store_data/rdata/unsigned in; strobe, wdata, load result and misaligned flag out.

Test Plan:
- ADD, result=0x1234, dst=5, no mem -> next edge dataM.result=0x1234, dst=5, is_bubble=0, stallM never high.
- LW, addr=0x1004, dbus_rdata=0x8000_0001_0000_0000, data_ok after 3 cycles:
  - stallM=1 for 3 cycles, dbus_valid steady, strobe=0.
  - dataM.result=0xFFFF_FFFF_8000_0001.
- SB, addr=0x2003, store_data=0xAB -> strobe=0x08, wdata[31:24]=0xAB, held until data_ok.
- LHU, addr=0x3001 (misaligned) -> no dbus_valid, misalign=1, dataM.is_bubble=1, no stall.
- flush one cycle after an LD issue:
  - dbus_valid held until data_ok (cycle 4); stallM drops on the flush cycle.
  - Response discarded; no non-bubble dataM for that LD.
- reset asserted mid-WAIT -> dbus_valid=0, dataM.is_bubble=1 immediately; FSM is IDLE after release.

Source files
------------

// File: rtl/memory_stage_pkg.sv
// Shared pipeline records and data-bus field widths for the MEM stage.
// Execute/memory records travel between stages unchanged in layout.
package memory_stage_pkg;

    localparam int XLEN        = 64;
    localparam int DBUS_ADDR_W = 64;
    localparam int DBUS_DATA_W = 64;
    localparam int DBUS_STRB_W = DBUS_DATA_W / 8;
    localparam int DBUS_SIZE_W = 2;

    typedef enum logic [1:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} msize_t;
    typedef logic [6:0] op_t;

    typedef struct packed {
        op_t    op;
        logic   mem_read;
        logic   mem_write;
        msize_t msize;
        logic   mem_unsigned;
    } ctl_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] result;
        ctl_t            ctl;
        logic [4:0]      dst;
        logic [XLEN-1:0] store_data;
        logic            is_bubble;
    } execute_data_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] result;
        ctl_t            ctl;
        logic [4:0]      dst;
        logic [XLEN-1:0] memory_address;
        logic            is_bubble;
    } memory_data_t;

    function automatic logic is_mem_op(execute_data_t d);
        return !d.is_bubble && (d.ctl.mem_read || d.ctl.mem_write);
    endfunction

    function automatic memory_data_t to_mem(execute_data_t d);
        memory_data_t m;
        m.pc             = d.pc;
        m.result         = d.result;
        m.ctl            = d.ctl;
        m.dst            = d.dst;
        m.is_bubble      = d.is_bubble;
        m.memory_address = (d.ctl.mem_read || d.ctl.mem_write) ? d.result : '0;
        return m;
    endfunction

    function automatic memory_data_t mem_bubble();
        memory_data_t m;
        m           = '0;
        m.is_bubble = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/memory_stage_align.sv
// Byte-lane steering for the data bus: store strobes/data, load extraction
// with sign/zero extension, and natural-alignment check.
module mem_align
    import memory_stage_pkg::*;
(
    input  logic [XLEN-1:0]        addr_i,
    input  msize_t                 msize_i,
    input  logic [XLEN-1:0]        store_data_i,
    input  logic [DBUS_DATA_W-1:0] rdata_i,
    input  logic                   unsigned_i,
    output logic [DBUS_STRB_W-1:0] strobe_o,
    output logic [DBUS_DATA_W-1:0] wdata_o,
    output logic [XLEN-1:0]        load_o,
    output logic                   misaligned_o
);

    logic [2:0]             off;
    logic [5:0]             sh;
    logic [7:0]             mask;
    logic [15:0]            strb_wide;
    logic [DBUS_DATA_W-1:0] raw;

    always_comb begin
        off = addr_i[2:0];
        sh  = {off, 3'b000};
        case (msize_i)
            MSIZE1:  begin mask = 8'h01; misaligned_o = 1'b0;         end
            MSIZE2:  begin mask = 8'h03; misaligned_o = addr_i[0];    end
            MSIZE4:  begin mask = 8'h0F; misaligned_o = |addr_i[1:0]; end
            default: begin mask = 8'hFF; misaligned_o = |off;         end
        endcase

        // Lanes shifted past byte 7 are dropped; only aligned accesses reach the bus.
        strb_wide = {8'h00, mask} << off;
        strobe_o  = strb_wide[7:0];
        wdata_o   = store_data_i << sh;

        raw = rdata_i >> sh;
        case (msize_i)
            MSIZE1:  load_o = unsigned_i ? {56'b0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
            MSIZE2:  load_o = unsigned_i ? {48'b0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
            MSIZE4:  load_o = unsigned_i ? {32'b0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
            default: load_o = raw;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// MEM stage: passes ALU results through, runs the data-bus handshake for
// loads/stores, and stalls execute while a request is outstanding.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  execute_data_t         dataE,
    input  logic                  flush,
    output logic                  stallM,
    output memory_data_t          dataM,
    output logic                  misalign,
    output logic                  dbus_valid,
    output logic [ADDR_W-1:0]     dbus_addr,
    output logic [1:0]            dbus_size,
    output logic [DATA_W/8-1:0]   dbus_strobe,
    output logic [DATA_W-1:0]     dbus_wdata,
    input  logic                  dbus_addr_ok,
    input  logic                  dbus_data_ok,
    input  logic [DATA_W-1:0]     dbus_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_t;

    state_t        state_q, state_d;
    execute_data_t req_q, req_d;
    memory_data_t  dataM_q, dataM_d;
    logic          misalign_q, misalign_d;

    execute_data_t   cur;
    memory_data_t    done_rec;
    logic            mem_e, valid, stall;
    logic [7:0]      strobe;
    logic [63:0]     wdata, load_res;
    logic            misaligned;
    logic            unused_addr_ok;

    // Acceptance is not needed: the request stays up until the response arrives.
    assign unused_addr_ok = dbus_addr_ok;

    // IDLE serves the incoming record; WAIT/DRAIN replay the latched request.
    assign cur   = (state_q == S_IDLE) ? dataE : req_q;
    assign mem_e = is_mem_op(dataE) && !flush;

    mem_align u_align (
        .addr_i       (cur.result),
        .msize_i      (cur.ctl.msize),
        .store_data_i (cur.store_data),
        .rdata_i      (dbus_rdata),
        .unsigned_i   (cur.ctl.mem_unsigned),
        .strobe_o     (strobe),
        .wdata_o      (wdata),
        .load_o       (load_res),
        .misaligned_o (misaligned)
    );

    always_comb begin
        done_rec = to_mem(cur);
        if (cur.ctl.mem_read) done_rec.result = load_res;
    end

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        dataM_d    = mem_bubble();
        misalign_d = 1'b0;
        valid      = 1'b0;
        stall      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_e) begin
                    if (misaligned) begin
                        dataM_d           = to_mem(dataE);
                        dataM_d.is_bubble = 1'b1;
                        misalign_d        = 1'b1;
                    end else begin
                        valid = 1'b1;
                        req_d = dataE;
                        if (dbus_data_ok) begin
                            dataM_d = done_rec;
                        end else begin
                            stall   = 1'b1;
                            state_d = S_WAIT;
                        end
                    end
                end else if (!flush) begin
                    dataM_d = to_mem(dataE);
                end
            end
            S_WAIT: begin
                valid = 1'b1;
                if (dbus_data_ok) begin
                    state_d = S_IDLE;
                    if (!flush) dataM_d = done_rec;
                end else if (flush) begin
                    state_d = S_DRAIN;
                end else begin
                    stall = 1'b1;
                end
            end
            S_DRAIN: begin
                // Orphaned request still owns the bus; non-mem work keeps flowing.
                valid = 1'b1;
                stall = mem_e;
                if (!mem_e && !flush) dataM_d = to_mem(dataE);
                if (dbus_data_ok) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            req_q      <= '0;
            dataM_q    <= mem_bubble();
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            dataM_q    <= dataM_d;
            misalign_q <= misalign_d;
        end
    end

    assign dataM       = dataM_q;
    assign misalign    = misalign_q;
    assign stallM      = stall && !reset;
    assign dbus_valid  = valid && !reset;
    assign dbus_addr   = cur.result[ADDR_W-1:0];
    assign dbus_size   = cur.ctl.msize;
    assign dbus_strobe = (dbus_valid && cur.ctl.mem_write && !cur.ctl.mem_read) ? strobe : '0;
    assign dbus_wdata  = wdata;

endmodule
